// File: rtl/bcd_pkg.sv
// Shared constants for the BCD carry receiver: digit limits, digit width
// and the active-high 7-segment codes (bit0 = seg a .. bit6 = seg g).
package bcd_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;
    typedef logic [6:0]         seg_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_MIN = 4'd0;

    localparam seg_t SEG_0   = 7'h3F;
    localparam seg_t SEG_1   = 7'h06;
    localparam seg_t SEG_2   = 7'h5B;
    localparam seg_t SEG_3   = 7'h4F;
    localparam seg_t SEG_4   = 7'h66;
    localparam seg_t SEG_5   = 7'h6D;
    localparam seg_t SEG_6   = 7'h7D;
    localparam seg_t SEG_7   = 7'h07;
    localparam seg_t SEG_8   = 7'h7F;
    localparam seg_t SEG_9   = 7'h6F;
    localparam seg_t SEG_OFF = 7'h00;

endpackage

// File: rtl/seg7_enc.sv
// BCD digit to active-high 7-segment code; non-BCD inputs blank the display.
module seg7_enc
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_Bcd,
    output logic [6:0]         o_Seg
);

    // Pure lookup of the fixed digit patterns.
    always_comb begin
        o_Seg = SEG_OFF;
        case (i_Bcd)
            4'd0:    o_Seg = SEG_0;
            4'd1:    o_Seg = SEG_1;
            4'd2:    o_Seg = SEG_2;
            4'd3:    o_Seg = SEG_3;
            4'd4:    o_Seg = SEG_4;
            4'd5:    o_Seg = SEG_5;
            4'd6:    o_Seg = SEG_6;
            4'd7:    o_Seg = SEG_7;
            4'd8:    o_Seg = SEG_8;
            4'd9:    o_Seg = SEG_9;
            default: o_Seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/bcd_carry_receiver.sv
// Two-digit (tens/hundreds) BCD up/down counter driven by the active-low
// carry/borrow strobe of a units-digit counter. Forwards its own wrap as a
// registered one-clock active-low carry.
// Optional feature: define CARRY_SYNC_EN to pass i_CarryN through a 2-flop
// synchronizer (count lands on the 3rd edge after the fall); otherwise the
// raw input is edge-detected (1st edge) for same-clock chaining.
module bcd_carry_receiver
    import bcd_pkg::*;
(
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_CarryN,
    input  logic       i_UpDnMode,
    input  logic       i_Clr,
    output logic [7:0] o_LED,
    output logic [6:0] o_FND_T,
    output logic [6:0] o_FND_H,
    output logic       o_CarryN
);

    logic carry_in;   // carry strobe as seen by the edge detector
    logic flushed;    // reset-time contents of the synchronizer have drained

`ifdef CARRY_SYNC_EN
    logic       sync1_q, sync2_q;
    logic [1:0] flush_q;

    // Two-flop synchronizer, idle-high at reset.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= i_CarryN;
            sync2_q <= sync1_q;
        end
    end

    // Counts the edges needed for the reset value to leave the synchronizer,
    // so the forced-high reset value is never mistaken for a real high level.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst)               flush_q <= 2'd0;
        else if (flush_q != 2'd2) flush_q <= flush_q + 2'd1;
    end

    assign carry_in = sync2_q;
    assign flushed  = (flush_q == 2'd2);
`else
    assign carry_in = i_CarryN;
    assign flushed  = 1'b1;
`endif

    logic prev_q;     // previous carry_in, idle-high at reset
    logic armed_q;    // a genuine high level has been seen since reset
    logic evt;

    // Edge-detect history plus arming: a strobe still low at reset release
    // must return high before its next fall can count.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            prev_q  <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= carry_in;
            armed_q <= armed_q | (flushed & carry_in);
        end
    end

    assign evt = armed_q & prev_q & ~carry_in;

    bcd_t tens_q, tens_d;
    bcd_t hund_q, hund_d;
    logic carry_q, carry_d;

    // Next-state for the two digits and the outgoing carry; clear wins over
    // a coincident event, which is dropped.
    always_comb begin
        tens_d  = tens_q;
        hund_d  = hund_q;
        carry_d = 1'b1;
        if (i_Clr) begin
            tens_d = BCD_MIN;
            hund_d = BCD_MIN;
        end else if (evt) begin
            if (!i_UpDnMode) begin
                if (tens_q >= BCD_MAX) begin
                    tens_d = BCD_MIN;
                    if (hund_q >= BCD_MAX) begin
                        hund_d  = BCD_MIN;
                        carry_d = 1'b0;
                    end else begin
                        hund_d = hund_q + 4'd1;
                    end
                end else begin
                    tens_d = tens_q + 4'd1;
                end
            end else begin
                if (tens_q == BCD_MIN) begin
                    tens_d = BCD_MAX;
                    if (hund_q == BCD_MIN) begin
                        hund_d  = BCD_MAX;
                        carry_d = 1'b0;
                    end else begin
                        hund_d = hund_q - 4'd1;
                    end
                end else begin
                    tens_d = tens_q - 4'd1;
                end
            end
        end
    end

    // Digit and carry-out registers.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            tens_q  <= BCD_MIN;
            hund_q  <= BCD_MIN;
            carry_q <= 1'b1;
        end else begin
            tens_q  <= tens_d;
            hund_q  <= hund_d;
            carry_q <= carry_d;
        end
    end

    assign o_LED    = {hund_q, tens_q};
    assign o_CarryN = carry_q;

    seg7_enc u_seg_t (.i_Bcd(tens_q), .o_Seg(o_FND_T));
    seg7_enc u_seg_h (.i_Bcd(hund_q), .o_Seg(o_FND_H));

endmodule

// File: doc/bcd_carry_receiver.md
BCD_CARRY_RECEIVER -- requirements
Module: bcd_carry_receiver

Interface
REQ-001 SHALL have port i_Clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port i_Rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port i_CarryN, input, 1, active-low carry/borrow event from the units-digit counter; idle high.
REQ-004 SHALL have port i_UpDnMode, input, 1, 0 = count up (carry), 1 = count down (borrow); quasi-static.
REQ-005 SHALL have port i_Clr, input, 1, synchronous clear of both digits.
REQ-006 SHALL have port o_LED, output, 8, {hundreds digit, tens digit} in BCD.
REQ-007 SHALL have port o_FND_T, output, 7, tens digit 7-segment code, bit0 = seg a .. bit6 = seg g, active-high.
REQ-008 SHALL have port o_FND_H, output, 7, hundreds digit 7-segment code, same encoding.
REQ-009 SHALL have port o_CarryN, output, 1, registered active-low carry/borrow to the next stage.

Function
REQ-010 SHALL detect a carry event as a high-to-low transition of the (optionally synchronized) i_CarryN, compared against a registered previous value; one event per falling edge, regardless of low duration.
REQ-011 SHALL require i_CarryN low >= 1 clock and high >= 1 clock between events; shorter pulses are out of contract.
REQ-012 SHALL sample i_UpDnMode at the clock edge that applies the event.
REQ-013 Up event: tens +1; tens 9 -> 0 with hundreds +1; hundreds 9 and tens 9 -> 00 (wrap).
REQ-014 Down event: tens -1; tens 0 -> 9 with hundreds -1; 00 -> 99 (wrap).
REQ-015 SHALL drive o_CarryN low for exactly one clock, registered at the same edge as the count update, only on the 99 -> 00 up wrap or the 00 -> 99 down wrap; high otherwise.
REQ-016 i_Clr SHALL force both digits to 0 and o_CarryN high at the next edge, with priority over a coincident event; that event SHALL be discarded.
REQ-017 Digits SHALL never hold values 10-15; 7-segment codes for 0-9 are fixed; o_FND_* are combinational from the registered digits.
REQ-018 Absent events, all registers SHALL hold.

Reset
REQ-019 On i_Rst high, both digits SHALL go to 0, o_LED = 8'h00, o_FND_T = o_FND_H = code for "0", o_CarryN = 1.
REQ-020 Synchronizer and previous-value flops SHALL reset to 1 (idle) so that release from reset with i_CarryN high produces no event.
REQ-021 Reset asserted mid-event SHALL abort the event; if i_CarryN is still low at release, no event SHALL be counted until it returns high and falls again.

Configuration
REQ-022 Macro CARRY_SYNC_EN defined: i_CarryN passes through a 2-flop synchronizer before edge detect; the count updates on the 3rd rising edge after i_CarryN falls.
REQ-023 Macro CARRY_SYNC_EN undefined: edge detect uses raw i_CarryN; the count updates on the 1st rising edge after i_CarryN falls; intended only for same-clock chaining.

Structure
REQ-024 Shared package bcd_pkg SHALL hold BCD_MAX (9), BCD_MIN (0), digit width (4), and the ten 7-segment code constants.
REQ-025 A single sub-module seg7_enc (4-bit BCD in, 7-bit code out) SHALL be instantiated twice; all other logic is in bcd_carry_receiver.

Verification (CARRY_SYNC_EN defined unless noted)
REQ-026 Reset, then 12 up events (i_CarryN low 2 clk, high 3 clk) -> o_LED = 8'h12, o_FND_T = "2", o_FND_H = "1", o_CarryN stays high.
REQ-027 Preload 99 via 99 up events, then 1 up event -> o_LED = 8'h00, o_CarryN low exactly one clock at the update edge.
REQ-028 From 00, i_UpDnMode = 1, 1 event -> o_LED = 8'h99 and a one-clock o_CarryN low; a 2nd event -> 8'h98 with o_CarryN high.
REQ-029 i_CarryN held low 20 clocks -> exactly one increment; i_Clr coincident with an event at count 8'h45 -> 8'h00, no carry output.
REQ-030 Reset asserted while i_CarryN is low, released with it still low -> count 00 and no event until the next high-to-low transition; without CARRY_SYNC_EN, update latency = 1 clock.
